dft_seq_ctrl: RTL and testbench

Sequencer for the 8-point DFT local RAM (x_real/x_imag input bank, X_real/X_imag output bank). It runs the whole transform in four phases: load time samples, compute all output bins via an external complex MAC, write each bin back, then stream the bins out. It drives every RAM control port and the RAM write-data source mux.

---
 rtl/dft_pkg.sv | 27 ++
 rtl/dft_idx_gen.sv | 73 +++++++
 rtl/dft_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dft_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_pkg.sv
// Shared constants and state encoding for the 8-point DFT RAM sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dft_pkg;

    localparam int SAMPLE           = 8;
    localparam int N_BIT_FOR_SAMPLE = 3;

    // RAM bank/plane selects: time-domain input bank and frequency-domain output bank
    localparam logic [1:0] SEL_X_IN  = 2'b00;
    localparam logic [1:0] SEL_X_OUT = 2'b10;

    // RAM data_in source mux
    localparam logic DIN_EXT = 1'b0;
    localparam logic DIN_ACC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_COMP     = 3'd2,
        ST_WAIT_ACC = 3'd3,
        ST_WRBACK   = 3'd4,
        ST_UNLD_RD  = 3'd5,
        ST_UNLD_OUT = 3'd6
    } state_t;

endpackage

// File: rtl/dft_idx_gen.sv
// Bin/sample counters, multiplier-free twiddle accumulator and MAC strobes.
// Latency: mac_en/first/last/tw_idx follow the read issue by one cycle (RAM read latency).
// Backpressure: none; counters move only when the sequencer asks.
module dft_idx_gen
    import dft_pkg::*;
#(
    parameter int sample           = SAMPLE,
    parameter int n_bit_for_sample = N_BIT_FOR_SAMPLE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        n_clr,
    input  logic                        n_inc,
    input  logic                        k_clr,
    input  logic                        k_inc,
    input  logic                        tw_clr,
    input  logic                        issue,
    output logic [n_bit_for_sample-1:0] n,
    output logic [n_bit_for_sample-1:0] k,
    output logic [n_bit_for_sample-1:0] n_nxt,
    output logic [n_bit_for_sample-1:0] k_nxt,
    output logic                        mac_en,
    output logic                        mac_first,
    output logic                        mac_last,
    output logic [n_bit_for_sample-1:0] tw_idx
);

    localparam logic [n_bit_for_sample-1:0] LAST_IDX = n_bit_for_sample'(sample - 1);
    localparam logic [n_bit_for_sample-1:0] ONE      = n_bit_for_sample'(1);

    // tw_acc tracks (n*k) mod N; wrap is free because N is a power of two
    logic [n_bit_for_sample-1:0] tw_acc;

    // Next counter values, exposed so the sequencer can register addresses in step
    always_comb begin
        n_nxt = n;
        k_nxt = k;
        if (n_clr)      n_nxt = '0;
        else if (n_inc) n_nxt = n + ONE;
        if (k_clr)      k_nxt = '0;
        else if (k_inc) k_nxt = k + ONE;
    end

    // Counter and twiddle accumulator state
    always_ff @(posedge clk) begin
        if (rst) begin
            n      <= '0;
            k      <= '0;
            tw_acc <= '0;
        end else begin
            n <= n_nxt;
            k <= k_nxt;
            if (tw_clr)     tw_acc <= '0;
            else if (issue) tw_acc <= tw_acc + k;
        end
    end

    // Delay the issue-time flags one cycle so they line up with RAM read data
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_en    <= 1'b0;
            mac_first <= 1'b0;
            mac_last  <= 1'b0;
            tw_idx    <= '0;
        end else begin
            mac_en    <= issue;
            mac_first <= issue && (n == '0);
            mac_last  <= issue && (n == LAST_IDX);
            tw_idx    <= issue ? tw_acc : '0;
        end
    end

endmodule

// File: rtl/dft_seq_ctrl.sv
// Four-phase DFT sequencer: load samples, MAC every bin, write bins back, stream bins out.
// Latency: outputs registered from next state; one RAM read per cycle in COMP, 1-cycle read before each output bin.
// Backpressure: in_valid low stalls LOAD, acc_valid holds WAIT_ACC, out_ready low holds UNLD_OUT with data stable.
module dft_seq_ctrl
    import dft_pkg::*;
#(
    parameter int sample           = SAMPLE,
    parameter int n_bit_for_sample = N_BIT_FOR_SAMPLE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [1:0]                  ram_wr_sel,
    output logic [1:0]                  ram_rd_sel,
    output logic                        ram_wr_en,
    output logic                        ram_sub_en,
    output logic [n_bit_for_sample-1:0] ram_addr,
    output logic                        din_sel,
    output logic                        mac_en,
    output logic                        mac_first,
    output logic                        mac_last,
    output logic [n_bit_for_sample-1:0] tw_idx,
    input  logic                        acc_valid,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done
);

    localparam logic [n_bit_for_sample-1:0] LAST_IDX = n_bit_for_sample'(sample - 1);

    state_t                      state, state_nxt;
    logic                        n_clr, n_inc, k_clr, k_inc, tw_clr, issue, done_nxt;
    logic [n_bit_for_sample-1:0] n, k, n_nxt, k_nxt, addr_nxt;
    logic                        wb_wr;
    logic                        last_seen;

    dft_idx_gen #(
        .sample           (sample),
        .n_bit_for_sample (n_bit_for_sample)
    ) u_idx_gen (
        .clk       (clk),
        .rst       (rst),
        .n_clr     (n_clr),
        .n_inc     (n_inc),
        .k_clr     (k_clr),
        .k_inc     (k_inc),
        .tw_clr    (tw_clr),
        .issue     (issue),
        .n         (n),
        .k         (k),
        .n_nxt     (n_nxt),
        .k_nxt     (k_nxt),
        .mac_en    (mac_en),
        .mac_first (mac_first),
        .mac_last  (mac_last),
        .tw_idx    (tw_idx)
    );

    // Next-state and counter control
    always_comb begin
        state_nxt = state;
        n_clr     = 1'b0;
        n_inc     = 1'b0;
        k_clr     = 1'b0;
        k_inc     = 1'b0;
        tw_clr    = 1'b0;
        issue     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                    n_clr     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (in_valid && in_ready) begin
                    if (n == LAST_IDX) begin
                        state_nxt = ST_COMP;
                        n_clr     = 1'b1;
                        k_clr     = 1'b1;
                        tw_clr    = 1'b1;
                    end else begin
                        n_inc = 1'b1;
                    end
                end
            end
            ST_COMP: begin
                issue = 1'b1;
                n_inc = 1'b1;
                if (n == LAST_IDX) begin
                    state_nxt = ST_WAIT_ACC;
                    n_clr     = 1'b1;
                end
            end
            ST_WAIT_ACC: begin
                // A stale acc_valid from before the final term must not trigger the writeback
                if (acc_valid && last_seen) state_nxt = ST_WRBACK;
            end
            ST_WRBACK: begin
                if (k == LAST_IDX) begin
                    state_nxt = ST_UNLD_RD;
                    k_clr     = 1'b1;
                end else begin
                    state_nxt = ST_COMP;
                    k_inc     = 1'b1;
                    n_clr     = 1'b1;
                    tw_clr    = 1'b1;
                end
            end
            ST_UNLD_RD: begin
                state_nxt = ST_UNLD_OUT;
            end
            ST_UNLD_OUT: begin
                if (out_ready) begin
                    if (k == LAST_IDX) begin
                        state_nxt = ST_IDLE;
                        k_clr     = 1'b1;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_UNLD_RD;
                        k_inc     = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // RAM address for the state being entered: sample index while loading/computing, bin index afterwards
    always_comb begin
        addr_nxt = '0;
        case (state_nxt)
            ST_LOAD, ST_COMP:                    addr_nxt = n_nxt;
            ST_WRBACK, ST_UNLD_RD, ST_UNLD_OUT:  addr_nxt = k_nxt;
            default:                             addr_nxt = '0;
        endcase
    end

    // State register and registered Moore outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            ram_wr_sel <= SEL_X_IN;
            ram_rd_sel <= SEL_X_IN;
            wb_wr      <= 1'b0;
            ram_sub_en <= 1'b0;
            ram_addr   <= '0;
            din_sel    <= DIN_EXT;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            last_seen  <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready   <= (state_nxt == ST_LOAD);
            ram_wr_sel <= (state_nxt == ST_WRBACK) ? SEL_X_OUT : SEL_X_IN;
            ram_rd_sel <= (state_nxt == ST_UNLD_RD || state_nxt == ST_UNLD_OUT) ? SEL_X_OUT : SEL_X_IN;
            wb_wr      <= (state_nxt == ST_WRBACK);
            ram_sub_en <= (state_nxt != ST_IDLE);
            ram_addr   <= addr_nxt;
            din_sel    <= (state_nxt == ST_WRBACK) ? DIN_ACC : DIN_EXT;
            out_valid  <= (state_nxt == ST_UNLD_OUT);
            busy       <= (state_nxt != ST_IDLE);
            done       <= done_nxt;
            last_seen  <= (state == ST_WAIT_ACC) && (last_seen || mac_last);
        end
    end

    // Load writes qualify the registered ready with the live valid; reset kills any write at once
    assign ram_wr_en = !rst && ((in_ready && in_valid) || wb_wr);

endmodule

// File: tb/tb_dft_seq_ctrl.sv
module tb_dft_seq_ctrl;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, acc_valid, out_ready;
    logic       in_ready, ram_wr_en, ram_sub_en, din_sel;
    logic       mac_en, mac_first, mac_last, out_valid, busy, done;
    logic [1:0] ram_wr_sel, ram_rd_sel;
    logic [2:0] ram_addr, tw_idx;

    always #5 clk = ~clk;

    dft_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ram_wr_sel (ram_wr_sel),
        .ram_rd_sel (ram_rd_sel),
        .ram_wr_en  (ram_wr_en),
        .ram_sub_en (ram_sub_en),
        .ram_addr   (ram_addr),
        .din_sel    (din_sel),
        .mac_en     (mac_en),
        .mac_first  (mac_first),
        .mac_last   (mac_last),
        .tw_idx     (tw_idx),
        .acc_valid  (acc_valid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    logic [19:0] outs;
    assign outs = {in_ready, ram_wr_sel, ram_rd_sel, ram_wr_en, ram_sub_en, ram_addr,
                   din_sel, mac_en, mac_first, mac_last, tw_idx, out_valid, busy, done};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference RAM banks, external data bus and behavioural complex MAC (twiddles scaled by 1000)
    int x_re [N] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int x_im [N] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int xo_re[N] = '{99, 99, 99, 99, 99, 99, 99, 99};
    int xo_im[N] = '{99, 99, 99, 99, 99, 99, 99, 99};
    int tw_c [N] = '{1000, 707, 0, -707, -1000, -707, 0, 707};
    int tw_s [N] = '{0, 707, 1000, 707, 0, -707, -1000, -707};
    int ext_re = 0, ext_im = 0;
    int rd_re = 0, rd_im = 0;
    int acc_re = 0, acc_im = 0;
    int load_cnt = 0, load_bad = 0, wb_cnt = 0, wb_bad = 0, wr_other = 0;
    int mac_cnt = 0, gap_ok = 0, cyc = 0, last_cyc = 0, dly = 0, pos_bin3 = 0;
    logic [23:0] tw_bin3    = '0;
    logic [7:0]  first_bin3 = '0;
    logic [7:0]  last_bin3  = '0;

    // Model evaluated late in each cycle, just before the rising edge it represents
    initial begin
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (rst) begin
                dly       = 0;
                acc_valid = 1'b0;
            end else begin
                if (mac_en) begin
                    if (mac_first) begin
                        acc_re = 0;
                        acc_im = 0;
                    end
                    acc_re += rd_re * tw_c[tw_idx] + rd_im * tw_s[tw_idx];
                    acc_im += rd_im * tw_c[tw_idx] - rd_re * tw_s[tw_idx];
                    mac_cnt++;
                    if (wb_cnt == 3 && pos_bin3 < 8) begin
                        tw_bin3[23 - 3*pos_bin3 -: 3] = tw_idx;
                        first_bin3[pos_bin3]          = mac_first;
                        last_bin3[pos_bin3]           = mac_last;
                        pos_bin3++;
                    end
                    if (mac_last) begin
                        dly      = 5;
                        last_cyc = cyc;
                    end
                end else if (dly > 0) begin
                    dly--;
                    if (dly == 0) acc_valid = 1'b1;
                end
            end
            if (ram_wr_en) begin
                if (ram_wr_sel == 2'b00) begin
                    if (int'(ram_addr) != load_cnt || din_sel || !ram_sub_en) load_bad++;
                    x_re[ram_addr] = ext_re;
                    x_im[ram_addr] = ext_im;
                    load_cnt++;
                end else if (ram_wr_sel == 2'b10) begin
                    if (int'(ram_addr) != wb_cnt || !din_sel || !ram_sub_en) wb_bad++;
                    if (cyc - last_cyc == 6) gap_ok++;
                    xo_re[ram_addr] = acc_re / 1000;
                    xo_im[ram_addr] = acc_im / 1000;
                    wb_cnt++;
                    acc_valid = 1'b0;
                end else begin
                    wr_other++;
                end
            end
            rd_re = (ram_rd_sel == 2'b10) ? xo_re[ram_addr] : x_re[ram_addr];
            rd_im = (ram_rd_sel == 2'b10) ? xo_im[ram_addr] : x_im[ram_addr];
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feed an impulse; with gaps the valid pattern per ready cycle is 1,0,1,1,0 repeating
    task automatic load_samples(input bit gaps);
        int sent  = 0;
        int p     = 0;
        int guard = 0;
        while (sent < 8 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (in_ready) begin
                in_valid = gaps ? ((p % 5) == 0 || (p % 5) == 2 || (p % 5) == 3) : 1'b1;
                if (in_valid) begin
                    ext_re = (sent == 0) ? 1 : 0;
                    ext_im = 0;
                    sent++;
                end
                p++;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_val("load_sent", 32'(sent), 32'd8);
        check_val("comp_entered", {30'd0, in_ready, busy}, 32'b01);
    endtask

    initial begin
        int wr_snap;
        int guard;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        acc_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outs", 32'(outs), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_outs", 32'(outs), 32'd0);

        // Run 1: contiguous load, then reset three cycles into COMP
        do_start();
        load_samples(1'b0);
        repeat (3) @(negedge clk);
        check_val("comp_mac_en", {31'd0, mac_en}, 32'd1);
        wr_snap = load_cnt + wb_cnt + wr_other;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_mid_comp_outs", 32'(outs), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_outs", 32'(outs), 32'd0);
        check_val("rst_no_write", 32'(load_cnt + wb_cnt + wr_other), 32'(wr_snap));

        // Run 2: full transform of an impulse with gapped load
        load_cnt = 0; load_bad = 0; wb_cnt = 0; wb_bad = 0; wr_other = 0;
        mac_cnt = 0; gap_ok = 0; pos_bin3 = 0;
        do_start();
        load_samples(1'b1);
        check_val("load_writes", 32'(load_cnt), 32'd8);
        check_val("load_bad", 32'(load_bad), 32'd0);

        for (int b = 0; b < N; b++) begin
            guard = 0;
            while (!out_valid && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            if (!out_valid) begin
                check_val("out_valid_timeout", 32'd0, 32'd1);
                break;
            end
            check_val("bin_addr", 32'(ram_addr), 32'(b));
            check_val("bin_data", {rd_re[15:0], rd_im[15:0]}, {16'd1, 16'd0});
            check_val("bin_done_low", {31'd0, done}, 32'd0);
            if (b == 2) begin
                repeat (4) begin
                    out_ready = 1'b0;
                    @(negedge clk);
                    check_val("hold_bin2", {20'd0, out_valid, ram_addr, rd_re[7:0]}, {20'd0, 1'b1, 3'd2, 8'd1});
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_val("valid_drop", {31'd0, out_valid}, 32'd0);
            if (b == N - 1) begin
                check_val("done_pulse", {30'd0, done, busy}, 32'b10);
                @(negedge clk);
                check_val("done_one_cycle", {31'd0, done}, 32'd0);
            end
        end

        check_val("wb_count", 32'(wb_cnt), 32'd8);
        check_val("wb_bad", 32'(wb_bad), 32'd0);
        check_val("wr_other", 32'(wr_other), 32'd0);
        check_val("wait_acc_gap", 32'(gap_ok), 32'd8);
        check_val("mac_pulses", 32'(mac_cnt), 32'd64);
        check_val("bin3_pulses", 32'(pos_bin3), 32'd8);
        check_val("bin3_tw_seq", {8'd0, tw_bin3}, {8'd0, 24'o03614725});
        check_val("bin3_first", {24'd0, first_bin3}, 32'h01);
        check_val("bin3_last", {24'd0, last_bin3}, 32'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
